// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB based on the IR
// opcode and decodes the current state into datapath enables, mux selects and
// the ALUOp class consumed by ALU control. MemReady stalls the memory states.
// Outputs are a Moore decode of the state register. The only exceptions are
// IRWrite/PCWrite in FETCH, which follow MemReady, and the IEXEC ALUOp/ZeroExt,
// which also decode Op. Every output is held at 0 while rst_n is low.
module multicycle_main_control #(
    parameter int STATE_W = 4,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Op,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ZeroExt,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_MEMADR = STATE_W'(2),
        S_MEMRD  = STATE_W'(3),
        S_MEMWB  = STATE_W'(4),
        S_MEMWR  = STATE_W'(5),
        S_EXEC   = STATE_W'(6),
        S_RWB    = STATE_W'(7),
        S_BRANCH = STATE_W'(8),
        S_JUMP   = STATE_W'(9),
        S_IEXEC  = STATE_W'(10),
        S_IWB    = STATE_W'(11)
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALUOP_ADDI  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALUOP_ANDI  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALUOP_ORI   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALUOP_XORI  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALUOP_SLTI  = ALUOP_W'(7);

    state_t state_reg;
    state_t state_next;

    // Next-state selection: memory states wait on MemReady, DECODE dispatches on Op
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (MemReady) state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:  state_next = S_MEMADR;
                    OP_R:          state_next = S_EXEC;
                    OP_BEQ:        state_next = S_BRANCH;
                    OP_J:          state_next = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:
                                   state_next = S_IEXEC;
                    default:       state_next = S_FETCH;  // unknown opcode: NOP
                endcase
            end
            S_MEMADR: state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (MemReady) state_next = S_MEMWB;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  if (MemReady) state_next = S_FETCH;
            S_EXEC:   state_next = S_RWB;
            S_RWB:    state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_IEXEC:  state_next = S_IWB;
            S_IWB:    state_next = S_FETCH;
            default:  state_next = S_FETCH;  // recover from illegal encodings
        endcase
    end

    // State register; reset aborts any instruction in flight and returns to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output decode of the current state, forced to 0 while reset is held
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ZeroExt     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = ALUOP_ADD;
        if (rst_n) begin
            case (state_reg)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;  // branch target precompute: PC + (imm << 2)
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    case (Op)
                        OP_ADDI: ALUOp = ALUOP_ADDI;
                        OP_ANDI: begin ALUOp = ALUOP_ANDI; ZeroExt = 1'b1; end
                        OP_ORI:  begin ALUOp = ALUOP_ORI;  ZeroExt = 1'b1; end
                        OP_XORI: begin ALUOp = ALUOP_XORI; ZeroExt = 1'b1; end
                        OP_SLTI: ALUOp = ALUOP_SLTI;
                        default: ALUOp = ALUOP_ADD;
                    endcase
                end
                S_IWB: begin
                    RegWrite = 1'b1;
                end
                default: begin
                    // illegal encodings drive nothing
                end
            endcase
        end
    end

    assign State = state_reg;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for the multicycle main control FSM: walks each instruction
// class through its state sequence and compares the state and the full output
// word against hand-derived values, including stalls and asynchronous reset.
module tb_multicycle_main_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ZeroExt;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;

    multicycle_main_control #(.STATE_W(4), .ALUOP_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt),
        .PCSource(PCSource), .ALUOp(ALUOp), .State(State)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output word order:
    // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
    // ALUSrcA ALUSrcB[1:0] ZeroExt PCSource[1:0] ALUOp[2:0]
    function automatic logic [17:0] ow(input logic pcw, input logic pcwc,
                                       input logic iord, input logic mrd,
                                       input logic mwr, input logic irw,
                                       input logic m2r, input logic rdst,
                                       input logic rw, input logic srca,
                                       input logic [1:0] srcb, input logic zext,
                                       input logic [1:0] pcs, input logic [2:0] aop);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, zext, pcs, aop};
    endfunction

    logic [17:0] outs;
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ZeroExt, PCSource, ALUOp};

    //                     pcw pcwc iord mrd mwr irw m2r rdst rw srca srcb  zx pcs   aop
    logic [17:0] W_ZERO, W_FR, W_FS, W_DEC, W_MADR, W_MRD, W_MWB, W_MWR;
    logic [17:0] W_EXEC, W_RWB, W_BR, W_JMP, W_IORI, W_ISLTI, W_IWB;
    initial begin
        W_ZERO  = ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000);
        W_FR    = ow(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 0, 2'b00, 3'b000);
        W_FS    = ow(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 3'b000);
        W_DEC   = ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 3'b000);
        W_MADR  = ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000);
        W_MRD   = ow(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000);
        W_MWB   = ow(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 3'b000);
        W_MWR   = ow(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000);
        W_EXEC  = ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 3'b010);
        W_RWB   = ow(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 3'b000);
        W_BR    = ow(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 3'b001);
        W_JMP   = ow(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 3'b000);
        W_IORI  = ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 2'b00, 3'b101);
        W_ISLTI = ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b111);
        W_IWB   = ow(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 3'b000);
    end

    task automatic test_reset();
        rst_n = 1'b0; MemReady = 1'b1; Op = 6'b100011;
        #3;
        total++;
        if (State !== 4'd0 || outs !== W_ZERO) begin
            bad++;
            $display("FAIL reset_held: state=%0d outs=%b, expected state=0 outs=%b", State, outs, W_ZERO);
        end else $display("reset_held ok state=%0d outs=%b", State, outs);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (State !== 4'd0 || outs !== W_ZERO) begin
            bad++;
            $display("FAIL reset_edges: state=%0d outs=%b, expected state=0 outs=%b", State, outs, W_ZERO);
        end else $display("reset_edges ok state=%0d outs=%b", State, outs);
        @(negedge clk);
        MemReady = 1'b0;
        rst_n = 1'b1;
        #1;
        total++;
        if (State !== 4'd0 || outs !== W_FS) begin
            bad++;
            $display("FAIL reset_release: state=%0d outs=%b, expected state=0 outs=%b", State, outs, W_FS);
        end else $display("reset_release ok state=%0d outs=%b", State, outs);
        @(posedge clk);
        #1;
        total++;
        if (State !== 4'd0 || outs !== W_FS) begin
            bad++;
            $display("FAIL reset_fetch_stall: state=%0d outs=%b, expected state=0 outs=%b", State, outs, W_FS);
        end else $display("reset_fetch_stall ok state=%0d outs=%b", State, outs);
    endtask

    task automatic test_lw();
        logic [3:0]  es[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [17:0] ew[5] = '{W_FR, W_DEC, W_MADR, W_MRD, W_MWB};
        Op = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            MemReady = 1'b1;
            #1;
            total++;
            if (State !== es[i] || outs !== ew[i]) begin
                bad++;
                $display("FAIL lw[%0d]: state=%0d outs=%b, expected state=%0d outs=%b", i, State, outs, es[i], ew[i]);
            end else $display("lw[%0d] ok state=%0d outs=%b", i, State, outs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  es[4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [17:0] ew[4] = '{W_FR, W_DEC, W_EXEC, W_RWB};
        Op = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            MemReady = 1'b1;
            #1;
            total++;
            if (State !== es[i] || outs !== ew[i]) begin
                bad++;
                $display("FAIL rtype[%0d]: state=%0d outs=%b, expected state=%0d outs=%b", i, State, outs, es[i], ew[i]);
            end else $display("rtype[%0d] ok state=%0d outs=%b", i, State, outs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0]  ops[2] = '{6'b000100, 6'b000010};
        logic [3:0]  es[3];
        logic [17:0] ew[3];
        for (int k = 0; k < 2; k++) begin
            Op = ops[k];
            es = '{4'd0, 4'd1, (k == 0) ? 4'd8 : 4'd9};
            ew = '{W_FR, W_DEC, (k == 0) ? W_BR : W_JMP};
            for (int i = 0; i < 3; i++) begin
                MemReady = 1'b1;
                #1;
                total++;
                if (State !== es[i] || outs !== ew[i]) begin
                    bad++;
                    $display("FAIL brj op=%b [%0d]: state=%0d outs=%b, expected state=%0d outs=%b", Op, i, State, outs, es[i], ew[i]);
                end else $display("brj op=%b [%0d] ok state=%0d outs=%b", Op, i, State, outs);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_itype();
        logic [5:0]  ops[2] = '{6'b001101, 6'b001010};
        logic [3:0]  es[4] = '{4'd0, 4'd1, 4'd10, 4'd11};
        logic [17:0] ew[4];
        for (int k = 0; k < 2; k++) begin
            Op = ops[k];
            ew = '{W_FR, W_DEC, (k == 0) ? W_IORI : W_ISLTI, W_IWB};
            for (int i = 0; i < 4; i++) begin
                MemReady = 1'b1;
                #1;
                total++;
                if (State !== es[i] || outs !== ew[i]) begin
                    bad++;
                    $display("FAIL itype op=%b [%0d]: state=%0d outs=%b, expected state=%0d outs=%b", Op, i, State, outs, es[i], ew[i]);
                end else $display("itype op=%b [%0d] ok state=%0d outs=%b", Op, i, State, outs);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_sw_stall();
        logic [3:0]  es[7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        logic        mr[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [17:0] ew[7] = '{W_FR, W_DEC, W_MADR, W_MWR, W_MWR, W_MWR, W_MWR};
        Op = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            MemReady = mr[i];
            #1;
            total++;
            if (State !== es[i] || outs !== ew[i]) begin
                bad++;
                $display("FAIL sw_stall[%0d]: state=%0d outs=%b, expected state=%0d outs=%b", i, State, outs, es[i], ew[i]);
            end else $display("sw_stall[%0d] ok state=%0d outs=%b", i, State, outs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_stall_nop();
        logic [3:0]  es[5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
        logic        mr[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [17:0] ew[5] = '{W_FS, W_FS, W_FR, W_DEC, W_FS};
        Op = 6'b111111;
        for (int i = 0; i < 5; i++) begin
            MemReady = mr[i];
            #1;
            total++;
            if (State !== es[i] || outs !== ew[i]) begin
                bad++;
                $display("FAIL nop[%0d]: state=%0d outs=%b, expected state=%0d outs=%b", i, State, outs, es[i], ew[i]);
            end else $display("nop[%0d] ok state=%0d outs=%b", i, State, outs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        // last cycle of the previous task left FETCH stalled with MemReady low
        logic [3:0]  es[4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [17:0] ew[4] = '{W_FR, W_DEC, W_MADR, W_MRD};
        Op = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            MemReady = (i < 3);
            #1;
            total++;
            if (State !== es[i] || outs !== ew[i]) begin
                bad++;
                $display("FAIL rmid_seq[%0d]: state=%0d outs=%b, expected state=%0d outs=%b", i, State, outs, es[i], ew[i]);
            end else $display("rmid_seq[%0d] ok state=%0d outs=%b", i, State, outs);
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (State !== 4'd0 || outs !== W_ZERO) begin
            bad++;
            $display("FAIL rmid_abort: state=%0d outs=%b, expected state=0 outs=%b", State, outs, W_ZERO);
        end else $display("rmid_abort ok state=%0d outs=%b", State, outs);
        MemReady = 1'b1;
        @(posedge clk); #1;
        total++;
        if (State !== 4'd0 || outs !== W_ZERO) begin
            bad++;
            $display("FAIL rmid_held: state=%0d outs=%b, expected state=0 outs=%b", State, outs, W_ZERO);
        end else $display("rmid_held ok state=%0d outs=%b", State, outs);
        rst_n = 1'b1;
        #1;
        total++;
        if (State !== 4'd0 || outs !== W_FR) begin
            bad++;
            $display("FAIL rmid_release: state=%0d outs=%b, expected state=0 outs=%b", State, outs, W_FR);
        end else $display("rmid_release ok state=%0d outs=%b", State, outs);
        @(posedge clk); #1;
        total++;
        if (State !== 4'd1 || outs !== W_DEC) begin
            bad++;
            $display("FAIL rmid_refetch: state=%0d outs=%b, expected state=1 outs=%b", State, outs, W_DEC);
        end else $display("rmid_refetch ok state=%0d outs=%b", State, outs);
    endtask

    initial begin
        rst_n = 1'b0;
        MemReady = 1'b0;
        Op = 6'b0;
        #1;
        test_reset();
        test_lw();
        test_rtype();
        test_branch_jump();
        test_itype();
        test_sw_stall();
        test_fetch_stall_nop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
